multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised multicycle control unit for the MIPS datapath: registered Moore FSM that sequences fetch, decode, address/execute, memory and write-back for ADD, ADDI, LW, SW, BEQ and B. Successor to the fixed-width controller: opcode width and encodings are parameters, every memory access stalls on a `mem_ready` handshake, unknown opcodes are flagged, and an optional watchdog aborts hung memory accesses. Sits between the instruction register opcode field and all datapath mux/enable strobes.

## Interface
- `OP_W`, 5, opcode width
- `OP_ADD`, 5'd0 / `OP_ADDI`, 5'd1 / `OP_LW`, 5'd2 / `OP_SW`, 5'd3 / `OP_BEQ`, 5'd4 / `OP_B`, 5'd5: opcode encodings, `OP_W` bits each
- `TIMEOUT_CYC`, 16, watchdog limit in cycles (must be ≥2; used only with `CTRL_TIMEOUT_EN`)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `op` in OP_W: opcode from IR, stable from DECODE through end of instruction
- `mem_ready` in 1: memory completes the current access this cycle
- `state` out 4: current state register
- `imem_read`, `mem_read`, `mem_write`, `iord`, `ir_write`, `pc_write`, `pc_write_cond` out 1: memory/PC/IR strobes
- `pc_source` out 2: 0 ALU result, 1 ALUOut (branch), 2 jump target
- `alu_src_a` out 1; `alu_src_b` out 2; `alu_op` out 2: 0 add, 1 sub, 2 funct
- `reg_dst`, `reg_write`, `mem_to_reg` out 1: register file controls
- `instr_done` out 1: one-cycle pulse at instruction retirement
- `illegal_op` out 1: one-cycle pulse on unknown opcode
- `mem_timeout` out 1: one-cycle pulse on watchdog abort (0 when compiled out)

## Operation
- States (encoding): IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_LW=4, MEM_SW=5, ADDI_WB=6, EXEC=7, RTYPE_WB=8, BRANCH=9, JUMP=10, LW_WB=11; 12–15 illegal → FETCH.
- Outputs decode from `state` only, except where gated by `mem_ready`; any output not listed for a state is 0.
- IDLE: all outputs 0; → FETCH unconditionally.
- FETCH: `imem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_source`=0; `ir_write`=`pc_write`=`mem_ready`; → DECODE when `mem_ready`, else stay.
- DECODE: `alu_src_b`=3, `alu_op`=0. ADD→EXEC; ADDI/LW/SW→MEM_ADDR; BEQ→BRANCH; B→JUMP; other → FETCH with `illegal_op`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0; LW→MEM_LW, SW→MEM_SW, ADDI→ADDI_WB.
- MEM_LW: `mem_read`=1, `iord`=1; → LW_WB on `mem_ready`.
- MEM_SW: `iord`=1, `mem_write`=1; `instr_done`=`mem_ready`; → FETCH on `mem_ready`.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1; → FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2; → RTYPE_WB.
- RTYPE_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1; → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write_cond`=1, `pc_source`=1, `instr_done`=1; → FETCH.
- JUMP: `pc_write`=1, `pc_source`=2, `instr_done`=1; → FETCH.
- LW_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1; → FETCH.

## Timing
- Reset asserted: `state`=IDLE immediately (asynchronous), so every output is 0. First FETCH one cycle after deassertion.
- Zero-wait latency (FETCH to retirement, inclusive): ADD 4, ADDI 4, LW 5, SW 4, BEQ 3, B 3 cycles. Each cycle `mem_ready` is low in FETCH/MEM_LW/MEM_SW adds one cycle.
- Wait states (FETCH, MEM_LW, MEM_SW) hold all request strobes steady until `mem_ready`; `pc_write`/`ir_write`/`instr_done` never fire early.
- Reset mid-instruction: abort at once, no further strobes; writes already committed are not undone.

## Configuration
- `CTRL_TIMEOUT_EN` defined: counter of width $clog2(TIMEOUT_CYC+1) increments each cycle spent in a wait state with `mem_ready`=0 and clears on any state change or `mem_ready`=1. If the count reaches `TIMEOUT_CYC`-1 and `mem_ready` is still 0, then `mem_timeout`=1 for that cycle and next state is FETCH (from FETCH: a refetch with no `pc_write`). If `mem_ready`=1 in the same cycle, completion wins and there is no timeout.
- Not defined: no counter; waits are unbounded; `mem_timeout` is tied to 0.

## Test plan
- Reset released, `mem_ready`=1, `op`=OP_ADD → states 0,1,2,7,8,1; `instr_done` pulses in cycle 5; `reg_dst`=1 and `reg_write`=1 in RTYPE_WB.
- `op`=OP_LW, `mem_ready` low 3 cycles in MEM_LW → `mem_read`=1 held 4 cycles, LW_WB with `mem_to_reg`=1, total 8 cycles.
- `op`=5'd31 → DECODE pulses `illegal_op` once, returns to FETCH with no `reg_write`/`mem_write`.
- `op`=OP_SW, `reset` asserted asynchronously mid-MEM_SW → `state`=0 and `mem_write`=0 before the next clock edge.
- `CTRL_TIMEOUT_EN`, `TIMEOUT_CYC`=4, `mem_ready` stuck 0 in MEM_SW → `mem_timeout` pulses in the 4th wait cycle, then FETCH; rerun with `mem_ready`=1 in that cycle → no timeout, `instr_done`=1.
- `op`=OP_BEQ then OP_B → BRANCH drives `alu_op`=1, `pc_write_cond`=1, `pc_source`=1; JUMP drives `pc_write`=1, `pc_source`=2; 3 cycles each.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: registered state, outputs decoded from state (plus mem_ready gating).
// Optional memory watchdog enabled by defining CTRL_TIMEOUT_EN.
module multicycle_ctrl #(
    parameter int              OP_W        = 5,
    parameter logic [OP_W-1:0] OP_ADD      = 5'd0,
    parameter logic [OP_W-1:0] OP_ADDI     = 5'd1,
    parameter logic [OP_W-1:0] OP_LW       = 5'd2,
    parameter logic [OP_W-1:0] OP_SW       = 5'd3,
    parameter logic [OP_W-1:0] OP_BEQ      = 5'd4,
    parameter logic [OP_W-1:0] OP_B        = 5'd5,
    parameter int              TIMEOUT_CYC = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic [3:0]      state,
    output logic            imem_read,
    output logic            mem_read,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic [1:0]      pc_source,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            instr_done,
    output logic            illegal_op,
    output logic            mem_timeout
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_LW   = 4'd4,
        MEM_SW   = 4'd5,
        ADDI_WB  = 4'd6,
        EXEC     = 4'd7,
        RTYPE_WB = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        LW_WB    = 4'd11
    } state_t;

    state_t cur;
    state_t base_next;
    state_t nxt;
    logic   in_wait;
    logic   timeout_hit;

    assign state   = cur;
    assign in_wait = (cur == FETCH) || (cur == MEM_LW) || (cur == MEM_SW);

    // Sequencing ignoring the watchdog; undefined encodings recover to FETCH.
    always_comb begin
        base_next = FETCH;
        case (cur)
            IDLE:     base_next = FETCH;
            FETCH:    base_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_ADD) begin
                    base_next = EXEC;
                end else if ((op == OP_ADDI) || (op == OP_LW) || (op == OP_SW)) begin
                    base_next = MEM_ADDR;
                end else if (op == OP_BEQ) begin
                    base_next = BRANCH;
                end else if (op == OP_B) begin
                    base_next = JUMP;
                end else begin
                    base_next = FETCH;
                end
            end
            MEM_ADDR: begin
                if (op == OP_LW) begin
                    base_next = MEM_LW;
                end else if (op == OP_SW) begin
                    base_next = MEM_SW;
                end else if (op == OP_ADDI) begin
                    base_next = ADDI_WB;
                end else begin
                    base_next = FETCH;
                end
            end
            MEM_LW:   base_next = mem_ready ? LW_WB : MEM_LW;
            MEM_SW:   base_next = mem_ready ? FETCH : MEM_SW;
            ADDI_WB:  base_next = FETCH;
            EXEC:     base_next = RTYPE_WB;
            RTYPE_WB: base_next = FETCH;
            BRANCH:   base_next = FETCH;
            JUMP:     base_next = FETCH;
            LW_WB:    base_next = FETCH;
            default:  base_next = FETCH;
        endcase
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // A completing access in the last allowed cycle takes priority over the abort.
    assign timeout_hit = in_wait && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Consecutive stalled cycles in the current wait state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!in_wait || mem_ready || timeout_hit || (nxt != cur)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign nxt = timeout_hit ? FETCH : base_next;

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Datapath strobes from the current state; only FETCH/MEM_SW commit on mem_ready.
    always_comb begin
        imem_read     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = timeout_hit;
        case (cur)
            FETCH: begin
                imem_read = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b  = 2'd3;
                illegal_op = (op != OP_ADD) && (op != OP_ADDI) && (op != OP_LW) &&
                             (op != OP_SW) && (op != OP_BEQ) && (op != OP_B);
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEM_LW: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_SW: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                instr_done = 1'b1;
            end
            LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                imem_read = 1'b0;
            end
        endcase
    end

endmodule
